// File: rtl/seq_det_sched.sv
// Round-robin scheduler sharing one overlapping "1001" detector next-state function across CH serial channels.
// Define SEQ_DET_SCHED_CNT_EN to add saturating per-channel detection counters and the cnt_sel/cnt_rd read port.
module seq_det_sched #(
   parameter int CH    = 4,
   parameter int CNT_W = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic [CH-1:0] in_valid,
   input  logic [CH-1:0] in_data,
   output logic [CH-1:0] in_ready,
   input  logic [CH-1:0] clr,
   output logic          det_valid,
   output logic [2:0]    det_ch
`ifdef SEQ_DET_SCHED_CNT_EN
   ,
   input  logic [2:0]       cnt_sel,
   output logic [CNT_W-1:0] cnt_rd
`endif
);

   localparam int IW = (CH > 1) ? $clog2(CH) : 1;
   localparam int CW = IW + 1;

   typedef enum logic [2:0] {
      S0    = 3'd0,
      S1    = 3'd1,
      S10   = 3'd2,
      S100  = 3'd3,
      S1001 = 3'd4
   } ctx_e;

   if (CH < 2 || CH > 8 || CNT_W < 1) begin : g_bad_param
      $error("seq_det_sched: CH must be 2..8 and CNT_W >= 1");
   end

   ctx_e          ctx_q [CH];
   ctx_e          ctx_d [CH];
   logic [IW-1:0] ptr_q, ptr_d;
   logic          det_valid_q, det_valid_d;
   logic [2:0]    det_ch_q, det_ch_d;

   logic          found;
   logic          xfer;
   logic [IW-1:0] gnt_idx;
   logic [CW-1:0] cand;
   ctx_e          ctx_nxt;

   // Illegal encodings fall back to S0 and can never report a detection.
   function automatic ctx_e ctx_next(input ctx_e s, input logic b);
      case (s)
         S0:      return b ? S1    : S0;
         S1:      return b ? S1    : S10;
         S10:     return b ? S1    : S100;
         S100:    return b ? S1001 : S0;
         S1001:   return b ? S1    : S10;
         default: return S0;
      endcase
   endfunction

   always_comb begin
      found    = 1'b0;
      gnt_idx  = '0;
      cand     = '0;
      in_ready = '0;
      for (int k = 0; k < CH; k++) begin
         cand = {1'b0, ptr_q} + CW'(k);
         if (cand >= CW'(CH)) cand = cand - CW'(CH);
         if (!found && in_valid[cand[IW-1:0]] && !clr[cand[IW-1:0]]) begin
            found   = 1'b1;
            gnt_idx = cand[IW-1:0];
         end
      end
      xfer = found & en & ~rst;
      if (xfer) in_ready[gnt_idx] = 1'b1;
   end

   always_comb begin
      ctx_nxt     = ctx_next(ctx_q[gnt_idx], in_data[gnt_idx]);
      det_valid_d = xfer && (ctx_nxt == S1001);
      det_ch_d    = det_valid_d ? 3'(gnt_idx) : det_ch_q;
      ptr_d       = ptr_q;
      if (xfer) ptr_d = (gnt_idx == IW'(CH - 1)) ? '0 : gnt_idx + IW'(1);
      for (int i = 0; i < CH; i++) begin
         ctx_d[i] = ctx_q[i];
         if (xfer && gnt_idx == IW'(i)) ctx_d[i] = ctx_nxt;
         if (clr[i]) ctx_d[i] = S0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < CH; i++) ctx_q[i] <= S0;
         ptr_q       <= '0;
         det_valid_q <= 1'b0;
         det_ch_q    <= '0;
      end else begin
         for (int i = 0; i < CH; i++) ctx_q[i] <= ctx_d[i];
         ptr_q       <= ptr_d;
         det_valid_q <= det_valid_d;
         det_ch_q    <= det_ch_d;
      end
   end

   assign det_valid = det_valid_q;
   assign det_ch    = det_ch_q;

`ifdef SEQ_DET_SCHED_CNT_EN
   logic [CNT_W-1:0] cnt_q [CH];
   logic [CNT_W-1:0] cnt_d [CH];
   logic [CNT_W-1:0] cnt_rd_q, cnt_rd_d;

   // Clear takes priority over a same-cycle increment.
   always_comb begin
      for (int i = 0; i < CH; i++) begin
         cnt_d[i] = cnt_q[i];
         if (det_valid_d && gnt_idx == IW'(i) && cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + CNT_W'(1);
         if (clr[i]) cnt_d[i] = '0;
      end
      cnt_rd_d = '0;
      if (int'(cnt_sel) < CH) cnt_rd_d = cnt_q[cnt_sel[IW-1:0]];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < CH; i++) cnt_q[i] <= '0;
         cnt_rd_q <= '0;
      end else begin
         for (int i = 0; i < CH; i++) cnt_q[i] <= cnt_d[i];
         cnt_rd_q <= cnt_rd_d;
      end
   end

   assign cnt_rd = cnt_rd_q;
`endif

endmodule

// File: tb/tb_seq_det_sched.sv
// Randomized scoreboard bench for seq_det_sched: a bit-window reference model predicts grants and detections.
module tb_seq_det_sched;
   localparam int CH    = 4;
   localparam int CNT_W = 2;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic          clk = 1'b0;
   logic          rst, en;
   logic [CH-1:0] in_valid, in_data, clr, in_ready;
   logic          det_valid;
   logic [2:0]    det_ch;
`ifdef SEQ_DET_SCHED_CNT_EN
   logic [2:0]       cnt_sel;
   logic [CNT_W-1:0] cnt_rd;
`endif

   seq_det_sched #(.CH(CH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .en(en),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .clr(clr), .det_valid(det_valid), .det_ch(det_ch)
`ifdef SEQ_DET_SCHED_CNT_EN
      , .cnt_sel(cnt_sel), .cnt_rd(cnt_rd)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int cyc; int ch; int val; } exp_t;

   int   vectors = 0, miscompares = 0, det_seen = 0;
   exp_t exp_q[$];
   exp_t cq[$];
   logic fq[CH][$];
   logic [3:0] hist[CH];
   int   cnt_m[CH];
   int   ptr_m = 0;
   int   sel_m = 0;

   task automatic chk(input string nm, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference model: a channel detects when its last four accepted bits since clear/reset read 1,0,0,1.
   task automatic step(input logic r, input logic e, input logic [CH-1:0] c);
      logic [CH-1:0] v, d;
      int g, exp_rdy, idx;
      exp_t x;
      for (int i = 0; i < CH; i++) begin
         v[i] = fq[i].size() > 0;
         d[i] = v[i] ? fq[i][0] : 1'b0;
      end
      rst = r; en = e; clr = c; in_valid = v; in_data = d;
`ifdef SEQ_DET_SCHED_CNT_EN
      cnt_sel = 3'(sel_m);
`endif
      #1;
      g = -1;
      if (!r && e) begin
         for (int k = 0; k < CH; k++) begin
            idx = (ptr_m + k) % CH;
            if (g < 0 && v[idx] && !c[idx]) g = idx;
         end
      end
      exp_rdy = (g >= 0) ? (1 << g) : 0;
      chk("in_ready", int'(in_ready), exp_rdy);
      x.cyc = cyc + 1; x.ch = 0;
      x.val = r ? 0 : ((sel_m < CH) ? cnt_m[sel_m] : 0);
      cq.push_back(x);
      if (r) begin
         for (int i = 0; i < CH; i++) begin hist[i] = 4'b0; cnt_m[i] = 0; end
         ptr_m = 0;
      end else begin
         if (g >= 0) begin
            hist[g] = {hist[g][2:0], d[g]};
            void'(fq[g].pop_front());
            ptr_m = (g + 1) % CH;
            if (hist[g] == 4'b1001) begin
               x.ch = g;
               exp_q.push_back(x);
               if (cnt_m[g] < CMAX) cnt_m[g]++;
            end
         end
         for (int i = 0; i < CH; i++) if (c[i]) begin hist[i] = 4'b0; cnt_m[i] = 0; end
      end
      @(negedge clk);
   endtask

   task automatic run();
      int guard, pend;
      guard = 0; pend = 1;
      while (pend > 0 && guard < 200) begin
         step(1'b0, 1'b1, '0);
         guard++;
         pend = 0;
         for (int i = 0; i < CH; i++) pend += fq[i].size();
      end
      chk("feed_drained", pend, 0);
      step(1'b0, 1'b1, '0);
   endtask

   task automatic feed(input int ch, input string bits);
      for (int i = 0; i < bits.len(); i++) fq[ch].push_back(bits[i] == "1");
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (det_valid) det_seen++;
      if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         e = exp_q.pop_front();
         chk("det_valid", int'(det_valid), 1);
         if (det_valid) chk("det_ch", int'(det_ch), e.ch);
      end else begin
         chk("det_valid_idle", int'(det_valid), 0);
      end
`ifdef SEQ_DET_SCHED_CNT_EN
      while (cq.size() > 0 && cq[0].cyc <= cyc) begin
         e = cq.pop_front();
         if (e.cyc == cyc) chk("cnt_rd", int'(cnt_rd), e.val);
      end
`else
      cq.delete();
`endif
   end

   initial begin
      int base;
      rst = 1'b1; en = 1'b0; in_valid = '0; in_data = '0; clr = '0;
`ifdef SEQ_DET_SCHED_CNT_EN
      cnt_sel = '0;
`endif
      for (int i = 0; i < CH; i++) begin hist[i] = 4'b0; cnt_m[i] = 0; end
      @(negedge clk);
      step(1'b1, 1'b0, '0);
      step(1'b1, 1'b1, '0);
      chk("det_valid_reset", int'(det_valid), 0);
      chk("det_ch_reset", int'(det_ch), 0);

      base = det_seen; feed(0, "1001"); run();
      chk("ch0_dets", det_seen - base, 1);

      base = det_seen; feed(2, "1001001"); run();
      chk("ch2_overlap_dets", det_seen - base, 2);

      step(1'b1, 1'b1, '0);
      base = det_seen;
      for (int i = 0; i < CH; i++) feed(i, "1001");
      run();
      chk("all_ch_dets", det_seen - base, 4);

      base = det_seen;
      feed(1, "100"); run();
      feed(1, "1"); step(1'b0, 1'b1, 4'b0010);
      run();
      chk("clr_no_det", det_seen - base, 0);
      feed(1, "1001"); run();
      chk("clr_then_det", det_seen - base, 1);

      base = det_seen;
      feed(3, "100"); run();
      step(1'b1, 1'b1, '0);
      feed(3, "1"); run();
      chk("rst_discard", det_seen - base, 0);

      step(1'b1, 1'b1, '0);
      base = det_seen;
      for (int i = 0; i < CH; i++) feed(i, "100");
      run();
      for (int i = 0; i < CH; i++) feed(i, "1");
      repeat (3) step(1'b0, 1'b0, '0);
      run();
      chk("en_hold_dets", det_seen - base, 4);

`ifdef SEQ_DET_SCHED_CNT_EN
      step(1'b1, 1'b1, '0);
      sel_m = 0; feed(0, "1001001001001001"); run();
      step(1'b0, 1'b1, '0);
      chk("cnt_saturated", int'(cnt_rd), CMAX);
      sel_m = 5; step(1'b0, 1'b1, '0); step(1'b0, 1'b1, '0);
      chk("cnt_sel_oob", int'(cnt_rd), 0);
      sel_m = 0; step(1'b0, 1'b1, 4'b0001); step(1'b0, 1'b1, '0);
      chk("cnt_clr", int'(cnt_rd), 0);
`endif

      repeat (2500) begin
         logic [CH-1:0] c;
         for (int i = 0; i < CH; i++) begin
            if (fq[i].size() == 0 && $urandom_range(0, 2) == 0) begin
               if ($urandom_range(0, 3) == 0) feed(i, "1001");
               else fq[i].push_back(1'($urandom_range(0, 1)));
            end
            c[i] = ($urandom_range(0, 49) == 0);
         end
         sel_m = $urandom_range(0, 7);
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0), c);
      end
      for (int i = 0; i < CH; i++) fq[i].delete();
      repeat (3) step(1'b0, 1'b1, '0);
      chk("det_queue_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
